// File: rtl/video_timing_pkg.sv
// Shared timing constants and parameter checks for the raster timing generator.
// The CC_* values are the 320x256 arcade timing that the default build reproduces.
package video_timing_pkg;

    localparam int CC_H_TOTAL     = 320;
    localparam int CC_H_ACT_START = 0;
    localparam int CC_H_ACT_END   = 256;
    localparam int CC_HS_START    = 272;
    localparam int CC_HS_END      = 304;
    localparam int CC_V_TOTAL     = 256;
    localparam int CC_V_ACT_START = 24;
    localparam int CC_V_ACT_END   = 256;
    localparam int CC_VS_START    = 4;
    localparam int CC_VS_END      = 7;
    localparam int CC_IRQ_FIRST   = 0;
    localparam int CC_IRQ_PERIOD  = 64;
    localparam int CC_FRAME_W     = 8;

    // True when pos lies in the half-open window [lo, hi).
    function automatic logic in_window(input int pos, input int lo, input int hi);
        return (pos >= lo) && (pos < hi);
    endfunction

    // One axis is sane when both windows are non-empty and fit inside the total.
    function automatic bit axis_ok(input int total, input int act_s, input int act_e,
                                   input int sync_s, input int sync_e);
        return (total >= 2) && (act_s < act_e) && (act_e <= total) &&
               (sync_s < sync_e) && (sync_e <= total);
    endfunction

    // Full parameter-set check evaluated at elaboration by the top level.
    function automatic bit timing_params_ok(
        input int h_total, input int h_act_s, input int h_act_e,
        input int hs_s,    input int hs_e,
        input int v_total, input int v_act_s, input int v_act_e,
        input int vs_s,    input int vs_e,
        input int irq_period
    );
        return axis_ok(h_total, h_act_s, h_act_e, hs_s, hs_e) &&
               axis_ok(v_total, v_act_s, v_act_e, vs_s, vs_e) &&
               (irq_period > 0);
    endfunction

endpackage

// File: rtl/video_timing_gen_axis.sv
// One raster axis: wrapping position counter with registered blank/sync flags.
// Flags are computed from the next count so they always describe the count
// that is presented on the same cycle (no pipeline skew).
module timing_axis
    import video_timing_pkg::*;
#(
    parameter int TOTAL      = CC_H_TOTAL,
    parameter int ACT_START  = CC_H_ACT_START,
    parameter int ACT_END    = CC_H_ACT_END,
    parameter int SYNC_START = CC_HS_START,
    parameter int SYNC_END   = CC_HS_END,
    parameter int W          = $clog2(TOTAL)
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         i_step,
    output logic [W-1:0] o_count,
    output logic         o_wrap,
    output logic         o_blank,
    output logic         o_blank_next,
    output logic         o_sync
);

    localparam logic [W-1:0] LAST      = W'(TOTAL - 1);
    localparam logic         RST_BLANK = !in_window(0, ACT_START, ACT_END);
    localparam logic         RST_SYNC  = in_window(0, SYNC_START, SYNC_END);

    logic [W-1:0] r_count;
    logic         r_blank;
    logic         r_sync;

    logic [W-1:0] w_next;
    logic         w_wrap;
    logic         w_blank_next;
    logic         w_sync_next;

    // Next position and the flags that will describe it.
    always_comb begin
        w_wrap = i_step && (r_count == LAST);
        w_next = r_count;
        if (i_step) begin
            w_next = w_wrap ? '0 : r_count + W'(1);
        end
        w_blank_next = !in_window(int'(w_next), ACT_START, ACT_END);
        w_sync_next  = in_window(int'(w_next), SYNC_START, SYNC_END);
    end

    // Position and flag registers; reset lands on position 0 with its flags.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count <= '0;
            r_blank <= RST_BLANK;
            r_sync  <= RST_SYNC;
        end else begin
            r_count <= w_next;
            r_blank <= w_blank_next;
            r_sync  <= w_sync_next;
        end
    end

    assign o_count      = r_count;
    assign o_wrap       = w_wrap;
    assign o_blank      = r_blank;
    assign o_blank_next = w_blank_next;
    assign o_sync       = r_sync;

endmodule

// File: rtl/video_timing_gen.sv
// Parametrised raster timing generator: H/V counters, sync, blanking, display
// enable, line/frame strobes, frame counter and an acknowledged raster IRQ.
//
// IRQ handshake: irq is a level that rises on a raster event and stays high
// until a single-clk irq_ack pulse. irq_ack is sampled on every clk (not gated
// by ce) so a CPU acknowledge is never lost. An event on the same clk as an ack
// wins: irq stays high and overrun is cleared, not set. An event while irq is
// already high (and not being acked) sets the sticky irq_overrun.
module video_timing_gen
    import video_timing_pkg::*;
#(
    parameter int H_TOTAL     = CC_H_TOTAL,
    parameter int H_ACT_START = CC_H_ACT_START,
    parameter int H_ACT_END   = CC_H_ACT_END,
    parameter int HS_START    = CC_HS_START,
    parameter int HS_END      = CC_HS_END,
    parameter int V_TOTAL     = CC_V_TOTAL,
    parameter int V_ACT_START = CC_V_ACT_START,
    parameter int V_ACT_END   = CC_V_ACT_END,
    parameter int VS_START    = CC_VS_START,
    parameter int VS_END      = CC_VS_END,
    parameter int IRQ_FIRST   = CC_IRQ_FIRST,
    parameter int IRQ_PERIOD  = CC_IRQ_PERIOD,
    parameter int FRAME_W     = CC_FRAME_W,
    localparam int HC_W       = $clog2(H_TOTAL),
    localparam int VC_W       = $clog2(V_TOTAL)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               ce,
    input  logic               irq_en,
    input  logic               irq_ack,
    output logic [HC_W-1:0]    hcount,
    output logic [VC_W-1:0]    vcount,
    output logic               hsync,
    output logic               vsync,
    output logic               hblank,
    output logic               vblank,
    output logic               de,
    output logic               line_start,
    output logic               frame_start,
    output logic [FRAME_W-1:0] frame_cnt,
    output logic               irq,
    output logic               irq_overrun
);

    if (!timing_params_ok(H_TOTAL, H_ACT_START, H_ACT_END, HS_START, HS_END,
                          V_TOTAL, V_ACT_START, V_ACT_END, VS_START, VS_END,
                          IRQ_PERIOD)) begin : g_bad_params
        $error("video_timing_gen: invalid timing parameters");
    end

    // Bit v is set when the line after v is an interrupt line, so the event
    // can be decoded from the current vcount on the cycle hcount wraps.
    function automatic logic [V_TOTAL-1:0] build_irq_pre_mask();
        logic [V_TOTAL-1:0] m;
        int                 per;
        int                 nxt;
        per = (IRQ_PERIOD > 0) ? IRQ_PERIOD : 1;
        m   = '0;
        for (int v = 0; v < V_TOTAL; v++) begin
            nxt = (v == V_TOTAL - 1) ? 0 : v + 1;
            if ((nxt >= IRQ_FIRST) && (((nxt - IRQ_FIRST) % per) == 0)) begin
                m[v] = 1'b1;
            end
        end
        return m;
    endfunction

    localparam logic [V_TOTAL-1:0] IRQ_PRE_MASK = build_irq_pre_mask();
    localparam logic RST_DE = in_window(0, H_ACT_START, H_ACT_END) &&
                              in_window(0, V_ACT_START, V_ACT_END);

    logic [HC_W-1:0]    w_hcount;
    logic [VC_W-1:0]    w_vcount;
    logic               w_h_wrap;
    logic               w_v_wrap;
    logic               w_hblank;
    logic               w_vblank;
    logic               w_hblank_next;
    logic               w_vblank_next;
    logic               w_hsync;
    logic               w_vsync;
    logic               w_irq_event;

    logic               r_line_start;
    logic               r_frame_start;
    logic               r_de;
    logic [FRAME_W-1:0] r_frame_cnt;
    logic               r_irq;
    logic               r_irq_overrun;

    timing_axis #(
        .TOTAL      (H_TOTAL),
        .ACT_START  (H_ACT_START),
        .ACT_END    (H_ACT_END),
        .SYNC_START (HS_START),
        .SYNC_END   (HS_END),
        .W          (HC_W)
    ) u_h_axis (
        .clk          (clk),
        .reset        (reset),
        .i_step       (ce),
        .o_count      (w_hcount),
        .o_wrap       (w_h_wrap),
        .o_blank      (w_hblank),
        .o_blank_next (w_hblank_next),
        .o_sync       (w_hsync)
    );

    timing_axis #(
        .TOTAL      (V_TOTAL),
        .ACT_START  (V_ACT_START),
        .ACT_END    (V_ACT_END),
        .SYNC_START (VS_START),
        .SYNC_END   (VS_END),
        .W          (VC_W)
    ) u_v_axis (
        .clk          (clk),
        .reset        (reset),
        .i_step       (w_h_wrap),
        .o_count      (w_vcount),
        .o_wrap       (w_v_wrap),
        .o_blank      (w_vblank),
        .o_blank_next (w_vblank_next),
        .o_sync       (w_vsync)
    );

    // Raster event: line wrap into an interrupt line while enabled.
    always_comb begin
        w_irq_event = w_h_wrap && irq_en && IRQ_PRE_MASK[w_vcount];
    end

    // Strobes, display enable and frame counter; strobes follow the wraps so
    // they last one clk and drop on the next clk whether or not ce is high.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_line_start  <= 1'b0;
            r_frame_start <= 1'b0;
            r_de          <= RST_DE;
            r_frame_cnt   <= '0;
        end else begin
            r_line_start  <= w_h_wrap;
            r_frame_start <= w_v_wrap;
            r_de          <= !w_hblank_next && !w_vblank_next;
            if (w_v_wrap) begin
                r_frame_cnt <= r_frame_cnt + FRAME_W'(1);
            end
        end
    end

    // Raster interrupt level and sticky overrun, cleared by acknowledge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_irq         <= 1'b0;
            r_irq_overrun <= 1'b0;
        end else if (w_irq_event) begin
            r_irq <= 1'b1;
            if (irq_ack) begin
                r_irq_overrun <= 1'b0;
            end else if (r_irq) begin
                r_irq_overrun <= 1'b1;
            end
        end else if (irq_ack) begin
            r_irq         <= 1'b0;
            r_irq_overrun <= 1'b0;
        end
    end

    assign hcount      = w_hcount;
    assign vcount      = w_vcount;
    assign hsync       = w_hsync;
    assign vsync       = w_vsync;
    assign hblank      = w_hblank;
    assign vblank      = w_vblank;
    assign de          = r_de;
    assign line_start  = r_line_start;
    assign frame_start = r_frame_start;
    assign frame_cnt   = r_frame_cnt;
    assign irq         = r_irq;
    assign irq_overrun = r_irq_overrun;

endmodule

// File: tb/tb_video_timing_gen.sv
// Directed bench for video_timing_gen: default 320x256 instance, an alternate
// 400x262 instance and a tiny 8x4 instance (fast frame and IRQ coverage).
// Expected values are hand-computed from the ce-edge count since reset release.
module tb_video_timing_gen;

    logic clk;
    logic reset;
    logic ce;
    logic irq_en;
    logic irq_ack;

    // default instance
    logic [8:0] d_hcount;
    logic [7:0] d_vcount;
    logic       d_hsync, d_vsync, d_hblank, d_vblank, d_de;
    logic       d_line_start, d_frame_start, d_irq, d_irq_overrun;
    logic [7:0] d_frame_cnt;
    // alternate 400x262 instance
    logic [8:0] a_hcount;
    logic [8:0] a_vcount;
    logic       a_hsync, a_vsync, a_hblank, a_vblank, a_de;
    logic       a_line_start, a_frame_start, a_irq, a_irq_overrun;
    logic [7:0] a_frame_cnt;
    // tiny 8x4 instance
    logic [2:0] s_hcount;
    logic [1:0] s_vcount;
    logic       s_hsync, s_vsync, s_hblank, s_vblank, s_de;
    logic       s_line_start, s_frame_start, s_irq, s_irq_overrun;
    logic [7:0] s_frame_cnt;

    int n_tests;
    int n_fail;
    int cyc;
    logic [31:0] exp_q[$];

    video_timing_gen u_dut (
        .clk(clk), .reset(reset), .ce(ce), .irq_en(irq_en), .irq_ack(irq_ack),
        .hcount(d_hcount), .vcount(d_vcount), .hsync(d_hsync), .vsync(d_vsync),
        .hblank(d_hblank), .vblank(d_vblank), .de(d_de),
        .line_start(d_line_start), .frame_start(d_frame_start),
        .frame_cnt(d_frame_cnt), .irq(d_irq), .irq_overrun(d_irq_overrun)
    );

    video_timing_gen #(.H_TOTAL(400), .V_TOTAL(262)) u_alt (
        .clk(clk), .reset(reset), .ce(ce), .irq_en(irq_en), .irq_ack(irq_ack),
        .hcount(a_hcount), .vcount(a_vcount), .hsync(a_hsync), .vsync(a_vsync),
        .hblank(a_hblank), .vblank(a_vblank), .de(a_de),
        .line_start(a_line_start), .frame_start(a_frame_start),
        .frame_cnt(a_frame_cnt), .irq(a_irq), .irq_overrun(a_irq_overrun)
    );

    video_timing_gen #(
        .H_TOTAL(8), .H_ACT_START(0), .H_ACT_END(6), .HS_START(6), .HS_END(7),
        .V_TOTAL(4), .V_ACT_START(1), .V_ACT_END(4), .VS_START(0), .VS_END(1),
        .IRQ_FIRST(1), .IRQ_PERIOD(2), .FRAME_W(8)
    ) u_small (
        .clk(clk), .reset(reset), .ce(ce), .irq_en(irq_en), .irq_ack(irq_ack),
        .hcount(s_hcount), .vcount(s_vcount), .hsync(s_hsync), .vsync(s_vsync),
        .hblank(s_hblank), .vblank(s_vblank), .de(s_de),
        .line_start(s_line_start), .frame_start(s_frame_start),
        .frame_cnt(s_frame_cnt), .irq(s_irq), .irq_overrun(s_irq_overrun)
    );

    // clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (ce edge %0d)", tag, got, exp, cyc);
        end
    endtask

    // advance with ce held high until 'target' ce edges since release
    task automatic goto(input int target);
        while (cyc < target) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    // one-clk acknowledge pulse while ce stays high
    task automatic ack_pulse();
        irq_ack = 1'b1;
        @(negedge clk);
        cyc++;
        irq_ack = 1'b0;
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        cyc     = 0;
        reset   = 1'b0;
        ce      = 1'b0;
        irq_en  = 1'b0;
        irq_ack = 1'b0;
        #1 reset = 1'b1;
        repeat (3) @(negedge clk);

        // reset state
        check("rst_hcount", d_hcount, 0);
        check("rst_vcount", d_vcount, 0);
        check("rst_frame_cnt", d_frame_cnt, 0);
        check("rst_irq", d_irq, 0);
        check("rst_overrun", d_irq_overrun, 0);
        check("rst_line_start", d_line_start, 0);
        check("rst_frame_start", d_frame_start, 0);
        check("rst_hsync", d_hsync, 0);
        check("rst_vsync", d_vsync, 0);
        check("rst_hblank", d_hblank, 0);
        check("rst_vblank", d_vblank, 1);
        check("rst_de", d_de, 0);
        check("rst_alt_vblank", a_vblank, 1);
        check("rst_small_vsync", s_vsync, 1);
        check("rst_small_vblank", s_vblank, 1);
        check("rst_small_hblank", s_hblank, 0);

        // release with ce held high
        reset  = 1'b0;
        ce     = 1'b1;
        irq_en = 1'b1;

        goto(1);
        check("first_ce_hcount", d_hcount, 1);
        check("first_ce_line_start", d_line_start, 0);
        check("small_first_hcount", s_hcount, 1);
        goto(7);
        check("small_irq_before", s_irq, 0);
        goto(8);
        check("small_vcount_1", s_vcount, 1);
        check("small_irq_rise", s_irq, 1);
        check("small_ovr_clear", s_irq_overrun, 0);
        goto(24);
        check("small_ovr_set", s_irq_overrun, 1);
        goto(31);
        check("small_h_last", s_hcount, 7);
        check("small_v_last", s_vcount, 3);
        check("small_fs_before", s_frame_start, 0);
        goto(32);
        check("small_fs_pulse", s_frame_start, 1);
        check("small_frame_cnt_1", s_frame_cnt, 1);
        check("small_v_wrap", s_vcount, 0);
        goto(33);
        check("small_fs_drop", s_frame_start, 0);

        goto(255);
        check("hblank_255", d_hblank, 0);
        goto(256);
        check("hblank_256", d_hblank, 1);
        goto(271);
        check("hsync_271", d_hsync, 0);
        goto(272);
        check("hsync_272", d_hsync, 1);
        goto(303);
        check("hsync_303", d_hsync, 1);
        goto(304);
        check("hsync_304", d_hsync, 0);
        goto(319);
        check("hcount_319", d_hcount, 319);
        check("hblank_319", d_hblank, 1);
        check("ls_319", d_line_start, 0);
        goto(320);
        check("hcount_wrap", d_hcount, 0);
        check("vcount_1", d_vcount, 1);
        check("ls_320", d_line_start, 1);
        check("alt_hcount_320", a_hcount, 320);
        check("alt_vcount_0", a_vcount, 0);
        check("alt_ls_320", a_line_start, 0);
        goto(321);
        check("ls_321", d_line_start, 0);
        check("hblank_321", d_hblank, 0);
        goto(399);
        check("alt_hcount_399", a_hcount, 399);
        goto(400);
        check("alt_hcount_wrap", a_hcount, 0);
        check("alt_vcount_1", a_vcount, 1);
        check("alt_ls_400", a_line_start, 1);
        goto(639);
        check("ls_639", d_line_start, 0);
        goto(640);
        check("ls_640", d_line_start, 1);
        check("vcount_2", d_vcount, 2);

        goto(965);
        check("vsync_v3", d_vsync, 0);
        goto(1285);
        check("vsync_v4", d_vsync, 1);
        goto(2020);
        check("vsync_v6", d_vsync, 1);
        goto(2245);
        check("vsync_v7", d_vsync, 0);
        goto(7370);
        check("vblank_v23", d_vblank, 1);
        check("de_v23", d_de, 0);
        goto(7680);
        check("vblank_v24", d_vblank, 0);
        check("de_v24_h0", d_de, 1);
        goto(7935);
        check("de_h255", d_de, 1);
        goto(7936);
        check("de_h256", d_de, 0);

        goto(8160);
        check("small_frame_cnt_255", s_frame_cnt, 255);
        goto(8192);
        check("small_frame_cnt_wrap", s_frame_cnt, 0);
        check("small_fs_wrap", s_frame_start, 1);

        // ack clears, enable low suppresses, enable low keeps pending irq
        goto(8204);
        ack_pulse();
        check("small_ack_irq", s_irq, 0);
        check("small_ack_ovr", s_irq_overrun, 0);
        irq_en = 1'b0;
        goto(8220);
        check("small_en_low_suppress", s_irq, 0);
        irq_en = 1'b1;
        goto(8232);
        check("small_irq_rerise", s_irq, 1);
        check("small_rerise_ovr", s_irq_overrun, 0);
        irq_en = 1'b0;
        goto(8250);
        check("small_en_low_hold", s_irq, 1);
        irq_en = 1'b1;

        // default raster interrupt at lines 64 / 128 / 192
        goto(20479);
        check("irq_before_v64", d_irq, 0);
        goto(20480);
        check("vcount_64", d_vcount, 64);
        check("irq_v64", d_irq, 1);
        check("ovr_v64", d_irq_overrun, 0);
        goto(40959);
        ack_pulse();
        check("coinc_vcount", d_vcount, 128);
        check("coinc_irq", d_irq, 1);
        check("coinc_ovr", d_irq_overrun, 0);
        goto(61439);
        check("ovr_before_v192", d_irq_overrun, 0);
        goto(61440);
        check("irq_v192", d_irq, 1);
        check("ovr_v192", d_irq_overrun, 1);
        goto(61500);
        ack_pulse();
        check("ack_irq", d_irq, 0);
        check("ack_ovr", d_irq_overrun, 0);

        // reset mid-frame at h=150, v=200
        goto(64150);
        check("pre_rst_hcount", d_hcount, 150);
        check("pre_rst_vcount", d_vcount, 200);
        check("pre_rst_de", d_de, 1);
        check("pre_rst_small_frame_cnt", s_frame_cnt, 212);
        check("pre_rst_small_irq", s_irq, 1);
        reset = 1'b1;
        ce    = 1'b0;
        #1;
        check("mid_rst_hcount", d_hcount, 0);
        check("mid_rst_vcount", d_vcount, 0);
        check("mid_rst_vblank", d_vblank, 1);
        check("mid_rst_de", d_de, 0);
        check("mid_rst_small_frame_cnt", s_frame_cnt, 0);
        check("mid_rst_small_irq", s_irq, 0);
        check("mid_rst_small_ovr", s_irq_overrun, 0);
        check("mid_rst_small_vsync", s_vsync, 1);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("release_ce_low_hcount", d_hcount, 0);

        // ce pulsed 1-in-4
        for (int p = 1; p <= 330; p++) begin
            for (int k = 0; k < 4; k++) exp_q.push_back(32'(p % 320));
            ce = 1'b1;
            @(negedge clk);
            ce = 1'b0;
            check($sformatf("pulse_hcount_%0d", p), d_hcount, exp_q.pop_front());
            check($sformatf("pulse_ls_%0d", p), d_line_start, 32'((p % 320) == 0));
            check($sformatf("pulse_fs_%0d", p), s_frame_start, 32'((p % 32) == 0));
            if (p == 320) check("pulse_vcount_1", d_vcount, 1);
            for (int k = 1; k < 4; k++) begin
                @(negedge clk);
                check($sformatf("hold_hcount_%0d_%0d", p, k), d_hcount, exp_q.pop_front());
                check($sformatf("hold_ls_%0d_%0d", p, k), d_line_start, 0);
                check($sformatf("hold_fs_%0d_%0d", p, k), s_frame_start, 0);
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
